// File: rtl/bg_pkg.sv
// Shared types and limits for the scrolling background renderer.
// Latency: none (types and constants only).
// Backpressure: none; the renderer free-runs with the pixel clock.
package bg_pkg;

  localparam int COORD_W         = 10;
  localparam int SCALE_SHIFT_MAX = 3;
  localparam int IDX_W_MAX       = 8;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t RGB_BLACK = '0;

endpackage

// File: rtl/bg_scroller_if.sv
// Scroll request channel: offset write strobe, wrap mode and ack/err pulses.
// Latency: ack/err pulse one cycle after the event that causes them.
// Backpressure: none; rejected requests are reported through scroll_err.
interface bg_scroller_if;
  import bg_pkg::*;

  logic [COORD_W-1:0] scroll_x_in;
  logic [COORD_W-1:0] scroll_y_in;
  logic               scroll_we;
  logic               wrap_en;
  logic               scroll_ack;
  logic               scroll_err;

  modport master (
    output scroll_x_in, scroll_y_in, scroll_we, wrap_en,
    input  scroll_ack, scroll_err
  );

  modport slave (
    input  scroll_x_in, scroll_y_in, scroll_we, wrap_en,
    output scroll_ack, scroll_err
  );

endinterface

// File: rtl/bg_addr_gen.sv
// Maps a screen pixel plus scroll offset to a source ROM address (wrap or border).
// Latency: 1 cycle, rom_addr and the out-of-range flag are registered together.
// Backpressure: none; a new pixel is accepted every cycle.
module bg_addr_gen
  import bg_pkg::*;
#(
  parameter int SRC_W       = 640,
  parameter int SRC_H       = 480,
  parameter int SCALE_SHIFT = 0,
  parameter int AW          = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] act_x,
  input  logic [COORD_W-1:0] act_y,
  input  logic               wrap,
  output logic [AW-1:0]      rom_addr,
  output logic               oor
);

  localparam logic [COORD_W:0] W_L   = (COORD_W+1)'(SRC_W);
  localparam logic [COORD_W:0] H_L   = (COORD_W+1)'(SRC_H);
  localparam logic [21:0]      W_MUL = 22'(SRC_W);

  logic [COORD_W:0] sx_raw, sy_raw, sx, sy;
  logic [21:0]      addr_full;
  logic [AW-1:0]    rom_addr_d, rom_addr_q;
  logic             oor_d, oor_q;
  logic             unused_addr_hi;

  // Offset add, one conditional subtract for wrap (offset < size keeps it exact), linear address.
  always_comb begin
    sx_raw = {1'b0, draw_x >> SCALE_SHIFT} + {1'b0, act_x};
    sy_raw = {1'b0, draw_y >> SCALE_SHIFT} + {1'b0, act_y};
    sx     = sx_raw;
    sy     = sy_raw;
    oor_d  = 1'b0;
    if (wrap) begin
      if (sx_raw >= W_L) sx = sx_raw - W_L;
      if (sy_raw >= H_L) sy = sy_raw - H_L;
    end else begin
      oor_d = (sx_raw >= W_L) || (sy_raw >= H_L);
    end
    addr_full  = {11'b0, sy} * W_MUL + {11'b0, sx};
    rom_addr_d = addr_full[AW-1:0];
  end

  // Address register feeding the synchronous ROM; the flag travels with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q <= '0;
      oor_q      <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      oor_q      <= oor_d;
    end
  end

  assign unused_addr_hi = ^addr_full[21:AW];
  assign rom_addr       = rom_addr_q;
  assign oor            = oor_q;

endmodule

// File: rtl/bg_scroller.sv
// Scrolling tiled background: frame-synchronous offset registers, ROM/palette pipeline, RGB out.
// Latency: 3 cycles from DrawX/DrawY to red/green/blue.
// Backpressure: none; bad scroll requests are dropped and flagged on scroll_err.
module bg_scroller
  import bg_pkg::*;
#(
  parameter int SRC_W       = 640,
  parameter int SRC_H       = 480,
  parameter int SCALE_SHIFT = 0,
  parameter int IDX_W       = 5,
  parameter int BORDER_IDX  = 0
) (
  input  logic                            vga_clk,
  input  logic                            reset,
  input  logic [COORD_W-1:0]              DrawX,
  input  logic [COORD_W-1:0]              DrawY,
  input  logic                            blank,
  bg_scroller_if.slave                    scr,
  output logic [$clog2(SRC_W*SRC_H)-1:0]  rom_addr,
  input  logic [IDX_W-1:0]                rom_q,
  output logic [IDX_W-1:0]                pal_idx,
  input  logic [11:0]                     pal_rgb,
  output logic [3:0]                      red,
  output logic [3:0]                      green,
  output logic [3:0]                      blue
);

  localparam int               AW       = $clog2(SRC_W*SRC_H);
  localparam logic [COORD_W:0] W_L      = (COORD_W+1)'(SRC_W);
  localparam logic [COORD_W:0] H_L      = (COORD_W+1)'(SRC_H);
  localparam logic [IDX_W-1:0] BORDER_L = IDX_W'(BORDER_IDX);

  logic [COORD_W-1:0] act_x_d, act_x_q, act_y_d, act_y_q;
  logic [COORD_W-1:0] shd_x_d, shd_x_q, shd_y_d, shd_y_q;
  logic               pend_d, pend_q, wrap_d, wrap_q;
  logic               ack_d, ack_q, err_d, err_q;
  logic               blank1_d, blank1_q, blank2_d, blank2_q;
  logic               vld1_d, vld1_q, vld2_d, vld2_q;
  logic               oor1, oor2_d, oor2_q;
  logic               frame_start, req_ok;
  rgb12_t             rgb_d, rgb_q;

  // Scroll bookkeeping: shadow takes requests any time, active offset only moves at frame start.
  always_comb begin
    frame_start = (DrawX == '0) && (DrawY == '0);
    req_ok      = ({1'b0, scr.scroll_x_in} < W_L) && ({1'b0, scr.scroll_y_in} < H_L);
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    shd_x_d     = shd_x_q;
    shd_y_d     = shd_y_q;
    pend_d      = pend_q;
    wrap_d      = wrap_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    if (frame_start) begin
      wrap_d = scr.wrap_en;
      if (pend_q) begin
        act_x_d = shd_x_q;
        act_y_d = shd_y_q;
        pend_d  = 1'b0;
        ack_d   = 1'b1;
      end
    end
    // A write landing on frame start re-arms pending for the following frame.
    if (scr.scroll_we) begin
      if (req_ok) begin
        shd_x_d = scr.scroll_x_in;
        shd_y_d = scr.scroll_y_in;
        pend_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Delay line: blank/valid/out-of-range follow the pixel to the ROM data and then to RGB.
  always_comb begin
    vld1_d   = 1'b1;
    vld2_d   = vld1_q;
    blank1_d = blank;
    blank2_d = blank1_q;
    oor2_d   = oor1;
    pal_idx  = !vld2_q ? '0 : (oor2_q ? BORDER_L : rom_q);
    rgb_d    = blank2_q ? rgb12_t'(pal_rgb) : RGB_BLACK;
  end

  // State and pipeline registers.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      act_x_q  <= '0;
      act_y_q  <= '0;
      shd_x_q  <= '0;
      shd_y_q  <= '0;
      pend_q   <= 1'b0;
      wrap_q   <= 1'b1;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      vld1_q   <= 1'b0;
      vld2_q   <= 1'b0;
      blank1_q <= 1'b0;
      blank2_q <= 1'b0;
      oor2_q   <= 1'b0;
      rgb_q    <= RGB_BLACK;
    end else begin
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
      shd_x_q  <= shd_x_d;
      shd_y_q  <= shd_y_d;
      pend_q   <= pend_d;
      wrap_q   <= wrap_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      vld1_q   <= vld1_d;
      vld2_q   <= vld2_d;
      blank1_q <= blank1_d;
      blank2_q <= blank2_d;
      oor2_q   <= oor2_d;
      rgb_q    <= rgb_d;
    end
  end

  // The next-state offset/mode is used so the frame-start pixel already sees the new frame's values.
  bg_addr_gen #(
    .SRC_W       (SRC_W),
    .SRC_H       (SRC_H),
    .SCALE_SHIFT (SCALE_SHIFT),
    .AW          (AW)
  ) u_addr (
    .clk      (vga_clk),
    .reset    (reset),
    .draw_x   (DrawX),
    .draw_y   (DrawY),
    .act_x    (act_x_d),
    .act_y    (act_y_d),
    .wrap     (wrap_d),
    .rom_addr (rom_addr),
    .oor      (oor1)
  );

  assign scr.scroll_ack = ack_q;
  assign scr.scroll_err = err_q;
  assign red            = rgb_q.r;
  assign green          = rgb_q.g;
  assign blue           = rgb_q.b;

endmodule

// File: tb/tb_bg_scroller.sv
// Directed bench for bg_scroller: default 640x480 instance plus a 320x240 x2-scaled instance.
// Expected values are queued when a pixel/request is driven and popped when the output is due.
// ROM is a registered model of the source image; palette is a combinational model.
module tb_bg_scroller;

  localparam int IDX_W = 5;
  localparam int AW0   = $clog2(640*480);
  localparam int AW1   = $clog2(320*240);

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic             reset;
  logic [9:0]       DrawX, DrawY;
  logic             blank;
  logic [AW0-1:0]   rom_addr0;
  logic [AW1-1:0]   rom_addr1;
  logic [IDX_W-1:0] rom_q0, rom_q1, pal_idx0, pal_idx1;
  logic [11:0]      pal_rgb0, pal_rgb1;
  logic [3:0]       red0, green0, blue0, red1, green1, blue1;

  bg_scroller_if if0 ();
  bg_scroller_if if1 ();

  bg_scroller dut0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .scr(if0), .rom_addr(rom_addr0), .rom_q(rom_q0), .pal_idx(pal_idx0),
    .pal_rgb(pal_rgb0), .red(red0), .green(green0), .blue(blue0)
  );

  bg_scroller #(.SRC_W(320), .SRC_H(240), .SCALE_SHIFT(1)) dut1 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .scr(if1), .rom_addr(rom_addr1), .rom_q(rom_q1), .pal_idx(pal_idx1),
    .pal_rgb(pal_rgb1), .red(red1), .green(green1), .blue(blue1)
  );

  function automatic logic [IDX_W-1:0] rom_f(input logic [31:0] a);
    return IDX_W'((a % 31) + 1);
  endfunction

  function automatic logic [11:0] pal_f(input logic [IDX_W-1:0] i);
    return {i[3:0], ~i[3:0], i[4], i[2:0]};
  endfunction

  always @(posedge vga_clk) begin
    rom_q0 <= rom_f(32'(rom_addr0));
    rom_q1 <= rom_f(32'(rom_addr1));
  end
  assign pal_rgb0 = pal_f(pal_idx0);
  assign pal_rgb1 = pal_f(pal_idx1);

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic want(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %0d required <nothing queued>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b);
    DrawX = x;
    DrawY = y;
    blank = b;
  endtask

  task automatic idle();
    pix(10'd700, 10'd500, 1'b0);
  endtask

  task automatic scroll0(input logic [9:0] x, input logic [9:0] y);
    if0.scroll_x_in = x;
    if0.scroll_y_in = y;
    if0.scroll_we   = 1'b1;
  endtask

  task automatic scroll1(input logic [9:0] x, input logic [9:0] y);
    if1.scroll_x_in = x;
    if1.scroll_y_in = y;
    if1.scroll_we   = 1'b1;
  endtask

  task automatic clr();
    if0.scroll_we = 1'b0;
    if1.scroll_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test required finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    if0.scroll_x_in = '0; if0.scroll_y_in = '0; if0.scroll_we = 1'b0; if0.wrap_en = 1'b1;
    if1.scroll_x_in = '0; if1.scroll_y_in = '0; if1.scroll_we = 1'b0; if1.wrap_en = 1'b1;
    step(); step();

    // reset state
    want("rst_rom_addr", 0);  check(32'(rom_addr0));
    want("rst_pal_idx", 0);   check(32'(pal_idx0));
    want("rst_rgb", 0);       check(32'({red0, green0, blue0}));
    want("rst_ack", 0);       check(32'(if0.scroll_ack));
    want("rst_err", 0);       check(32'(if0.scroll_err));
    reset = 1'b0;

    // offset (0,0), pixel (5,2): address at T1, palette colour at T3
    pix(10'd5, 10'd2, 1'b1);
    want("t1_addr_5_2", 1285);
    want("t2_idx_5_2", 32'(rom_f(1285)));
    want("t3_rgb_5_2", 32'(pal_f(rom_f(1285))));
    step(); idle();
    check(32'(rom_addr0));
    step(); check(32'(pal_idx0));
    step(); check(32'({red0, green0, blue0}));

    // same pixel blanked: index still fetched, colour forced black
    pix(10'd5, 10'd2, 1'b0);
    want("t2_idx_blanked", 32'(rom_f(1285)));
    want("t3_rgb_blanked", 0);
    step(); idle();
    step(); check(32'(pal_idx0));
    step(); check(32'({red0, green0, blue0}));

    // border mode with scroll (600,0)
    if0.wrap_en = 1'b0;
    scroll0(10'd600, 10'd0);
    want("req600_err", 0);
    want("req600_early_ack", 0);
    step(); clr();
    check(32'(if0.scroll_err));
    check(32'(if0.scroll_ack));
    pix(10'd0, 10'd0, 1'b1);
    want("fs600_ack", 1);
    want("fs600_addr", 600);
    step();
    check(32'(if0.scroll_ack));
    check(32'(rom_addr0));
    pix(10'd50, 10'd0, 1'b1);
    want("ack_one_cycle", 0);
    step(); check(32'(if0.scroll_ack));
    pix(10'd30, 10'd0, 1'b1);
    want("border_idx_x50", 0);
    want("addr_x30", 630);
    step();
    check(32'(pal_idx0));
    check(32'(rom_addr0));
    idle();
    want("border_rgb_x50", 32'(pal_f(0)));
    want("idx_x30", 32'(rom_f(630)));
    step();
    check(32'({red0, green0, blue0}));
    check(32'(pal_idx0));
    want("rgb_x30", 32'(pal_f(rom_f(630))));
    step(); check(32'({red0, green0, blue0}));

    // rejected request (700,0)
    scroll0(10'd700, 10'd0);
    want("req700_err", 1);
    step(); clr();
    check(32'(if0.scroll_err));
    want("req700_err_pulse", 0);
    step(); check(32'(if0.scroll_err));
    pix(10'd0, 10'd0, 1'b0);
    want("req700_no_ack", 0);
    want("req700_offset_kept", 600);
    step();
    check(32'(if0.scroll_ack));
    check(32'(rom_addr0));
    idle();

    // two writes in one frame: last one wins, one ack
    if0.wrap_en = 1'b1;
    scroll0(10'd10, 10'd0);
    step(); clr();
    step();
    scroll0(10'd20, 10'd0);
    want("multi_no_early_ack", 0);
    step(); clr();
    check(32'(if0.scroll_ack));
    pix(10'd0, 10'd0, 1'b0);
    want("multi_ack", 1);
    want("multi_addr", 20);
    step();
    check(32'(if0.scroll_ack));
    check(32'(rom_addr0));
    idle();
    want("multi_ack_pulse", 0);
    step(); check(32'(if0.scroll_ack));
    pix(10'd0, 10'd0, 1'b0);
    want("multi_second_fs_ack", 0);
    want("multi_second_fs_addr", 20);
    step();
    check(32'(if0.scroll_ack));
    check(32'(rom_addr0));
    idle();

    // write coinciding with frame start while pending
    scroll0(10'd30, 10'd0);
    step(); clr();
    pix(10'd0, 10'd0, 1'b0);
    scroll0(10'd40, 10'd0);
    want("coin_ack_old", 1);
    want("coin_addr_old", 30);
    step(); clr(); idle();
    check(32'(if0.scroll_ack));
    check(32'(rom_addr0));
    want("coin_ack_pulse", 0);
    step(); check(32'(if0.scroll_ack));
    pix(10'd0, 10'd0, 1'b0);
    want("coin_ack_new", 1);
    want("coin_addr_new", 40);
    step();
    check(32'(if0.scroll_ack));
    check(32'(rom_addr0));
    idle();

    // reset mid-frame: black until refilled, offset back to (0,0)
    pix(10'd5, 10'd2, 1'b1);
    step();
    reset = 1'b1;
    want("midrst_rgb", 0);
    want("midrst_addr", 0);
    step();
    check(32'({red0, green0, blue0}));
    check(32'(rom_addr0));
    reset = 1'b0;
    pix(10'd5, 10'd2, 1'b1);
    want("refill_rgb_t1", 0);
    want("refill_addr", 1285);
    step();
    check(32'({red0, green0, blue0}));
    check(32'(rom_addr0));
    idle();
    want("refill_rgb_t2", 0);
    step(); check(32'({red0, green0, blue0}));
    want("refill_rgb_t3", 32'(pal_f(rom_f(1285))));
    step(); check(32'({red0, green0, blue0}));
    pix(10'd0, 10'd0, 1'b0);
    want("postrst_fs_addr", 0);
    want("postrst_fs_ack", 0);
    step();
    check(32'(rom_addr0));
    check(32'(if0.scroll_ack));
    idle();

    // scaled 320x240 instance: scroll (300,230), pixel (100,40)
    scroll1(10'd320, 10'd0);
    want("s1_req320_err", 1);
    step(); clr();
    check(32'(if1.scroll_err));
    scroll1(10'd300, 10'd230);
    want("s1_req_err", 0);
    step(); clr();
    check(32'(if1.scroll_err));
    pix(10'd0, 10'd0, 1'b0);
    want("s1_fs_ack", 1);
    want("s1_fs_addr", 73900);
    step();
    check(32'(if1.scroll_ack));
    check(32'(rom_addr1));
    pix(10'd100, 10'd40, 1'b1);
    want("s1_addr_wrap", 3230);
    want("s1_idx_wrap", 32'(rom_f(3230)));
    want("s1_rgb_wrap", 32'(pal_f(rom_f(3230))));
    step(); idle();
    check(32'(rom_addr1));
    step(); check(32'(pal_idx1));
    step(); check(32'({red1, green1, blue1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
